// File: rtl/uart_rx.sv
// uart_rx: 8N1 serial receiver with a two-flop input synchronizer,
// start-bit glitch rejection and framing-error / line-break handling.
module uart_rx #(
    parameter int CLKS_PER_BIT = 87
) (
    input  logic       i_Clock,
    input  logic       i_Rst_n,
    input  logic       i_Rx_Serial,
    output logic       o_Rx_DV,
    output logic [7:0] o_Rx_Byte,
    output logic       o_Rx_Err,
    output logic       o_Rx_Busy
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
    // The IDLE detection cycle already counts toward the half-bit wait.
    localparam logic [CW-1:0] MID = CW'((CLKS_PER_BIT - 1) / 2 - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        CLEANUP,
        BREAK
    } state_t;

    state_t        state;
    logic [1:0]    sync;
    logic          rx_s;
    logic [CW-1:0] cnt;
    logic [2:0]    idx;
    logic [7:0]    shift;

    assign rx_s      = sync[1];
    assign o_Rx_Busy = (state != IDLE);

    always_ff @(posedge i_Clock or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            sync <= 2'b11;
        end else begin
            sync <= {sync[0], i_Rx_Serial};
        end
    end

    always_ff @(posedge i_Clock or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            idx       <= '0;
            shift     <= '0;
            o_Rx_DV   <= 1'b0;
            o_Rx_Err  <= 1'b0;
            o_Rx_Byte <= 8'h00;
        end else begin
            o_Rx_DV  <= 1'b0;
            o_Rx_Err <= 1'b0;
            unique case (state)
                IDLE: begin
                    cnt <= '0;
                    idx <= '0;
                    if (!rx_s) begin
                        state <= START;
                    end
                end
                START: begin
                    if (cnt == MID) begin
                        cnt   <= '0;
                        idx   <= '0;
                        state <= rx_s ? IDLE : DATA;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DATA: begin
                    if (cnt == LAST) begin
                        cnt        <= '0;
                        shift[idx] <= rx_s;
                        if (idx == 3'd7) begin
                            state <= STOP;
                        end else begin
                            idx <= idx + 1'b1;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                STOP: begin
                    if (cnt == LAST) begin
                        cnt <= '0;
                        if (rx_s) begin
                            o_Rx_Byte <= shift;
                            o_Rx_DV   <= 1'b1;
                            state     <= CLEANUP;
                        end else begin
                            o_Rx_Err <= 1'b1;
                            state    <= BREAK;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                CLEANUP: begin
                    state <= IDLE;
                end
                BREAK: begin
                    if (rx_s) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 Parameter CLKS_PER_BIT, default 87, i_Clock cycles per serial bit; legal range 4..65535.
REQ-002 i_Clock  input  1  system clock; all state updates on its rising edge.
REQ-003 i_Rst_n  input  1  asynchronous, active-low reset.
REQ-004 i_Rx_Serial  input  1  asynchronous serial line; idles high; 8N1 framing, LSB first.
REQ-005 o_Rx_DV  output  1  one-cycle strobe; o_Rx_Byte is valid in that cycle.
REQ-006 o_Rx_Byte  output  8  last correctly framed byte; holds between strobes.
REQ-007 o_Rx_Err  output  1  one-cycle strobe on a framing error (stop bit sampled low).
REQ-008 o_Rx_Busy  output  1  high whenever the FSM is not IDLE.

Function
REQ-009 Two-flop synchronizer on i_Rx_Serial, both flops reset to 1; the FSM uses only the synchronized value (rx_s).
REQ-010 FSM states: IDLE, START, DATA, STOP, CLEANUP, BREAK.
REQ-011 Bit counter width is clog2(CLKS_PER_BIT); bit index is 3 bits.
REQ-012 IDLE: on rx_s==0, go to START with the counter cleared; otherwise hold.
REQ-013 START: count to (CLKS_PER_BIT-1)/2 (integer divide), which is mid start bit.
REQ-014 At mid start bit, if rx_s==0, go to DATA with the counter and index cleared.
REQ-015 At mid start bit, if rx_s==1, treat it as a glitch and return to IDLE; no output strobes.
REQ-016 DATA: count to CLKS_PER_BIT-1.
REQ-017 At terminal count, clear the counter and shift rx_s into shift register bit [index].
REQ-018 After the index-7 sample, go to STOP; otherwise increment the index.
REQ-019 STOP: count to CLKS_PER_BIT-1, then sample rx_s.
REQ-020 STOP sample of 1: load o_Rx_Byte from the shift register, assert o_Rx_DV for exactly one cycle, go to CLEANUP.
REQ-021 STOP sample of 0: assert o_Rx_Err for exactly one cycle, leave o_Rx_Byte unchanged, go to BREAK.
REQ-022 CLEANUP: lasts one cycle, then go to IDLE.
REQ-023 BREAK: hold until rx_s==1, then go to IDLE; a line held low never produces a second frame.
REQ-024 o_Rx_DV and o_Rx_Err are never high in the same cycle.
REQ-025 Start detection for the next frame is possible in the first IDLE cycle after CLEANUP, so back-to-back frames with no extra idle bits are received.
REQ-026 Latency from the start-bit falling edge at the pin to the o_Rx_DV rising edge is 2 + (CLKS_PER_BIT-1)/2 + 9*CLKS_PER_BIT cycles, +/-1 cycle.
REQ-027 Shift register content is don't-care outside of strobes; only o_Rx_Byte is architectural.

Reset
REQ-028 While i_Rst_n==0, outputs are forced immediately, independent of the clock: o_Rx_DV=0, o_Rx_Err=0, o_Rx_Byte=8'h00, o_Rx_Busy=0.
REQ-029 While i_Rst_n==0, internal state is forced: FSM=IDLE, counter=0, index=0, synchronizer=2'b11.
REQ-030 Reset asserted mid-frame discards the partial byte; no strobe is issued for that frame.
REQ-031 After reset release, the first frame is accepted only after a falling edge on rx_s.
REQ-032 A line held low through reset release is handled as follows: rx_s falls to 0 after 2 cycles, the FSM enters START, and a frame is received if timing is met.

Verification (CLKS_PER_BIT=8 unless stated)
REQ-033 Scenario: send frame 0xA5 with stop=1 -> o_Rx_DV pulses once for 1 cycle, o_Rx_Byte=8'hA5, o_Rx_Err stays 0, DV at 2+3+72 cycles +/-1 after the start edge.
REQ-034 Scenario: 2-cycle low glitch on an idle line -> FSM returns to IDLE; no DV, no Err, o_Rx_Byte unchanged.
REQ-035 Scenario: frame 0x3C with stop bit driven 0, then line high -> one Err pulse, no DV, o_Rx_Byte keeps its previous value, o_Rx_Busy drops once the line is high.
REQ-036 Scenario: back-to-back frames 0x00, 0xFF, 0x55 with no idle gap -> three DV pulses carrying 0x00, 0xFF, 0x55 in order.
REQ-037 Scenario: i_Rst_n pulsed low during data bit 4 of 0x81, then a clean 0x7E -> no strobe for the partial frame; one DV with 0x7E.
REQ-038 Scenario: CLKS_PER_BIT=87, random bytes with +/-2% baud skew -> every byte received correctly; Err never asserts.
